// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with occupancy, thresholds, sticky errors and flush
module fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rdata;
  logic              r_overflow;
  logic              r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;

  // Status flags decode the registered count only, so wr/rd never reach them combinationally
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == DEPTH_C);
    // A full FIFO still takes a write when a read frees a slot in the same cycle
    w_rd_ok = rd & ~w_empty;
    w_wr_ok = wr & (~w_full | rd);
  end

  // Storage array has no reset; writes are suppressed while in reset or flushing
  always_ff @(posedge clk) begin
    if (reset && !clr && w_wr_ok) begin
      r_mem[r_wr_ptr] <= w_data;
    end
  end

  // Pointers, occupancy, registered read data and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rdata     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      // Flush wins over same-cycle requests, which are dropped without raising errors
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rdata     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rdata  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    r_data       = r_rdata;
    count        = r_count;
    empty        = w_empty;
    full         = w_full;
    almost_empty = (r_count <= AE_C);
    almost_full  = (r_count >= AF_C);
    overflow     = r_overflow;
    underflow    = r_underflow;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised successor to the team's 8-bit synchronous FIFO.
- Generalised data width and depth; adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Single clock domain; used as the standard buffer between datapath stages and UART/bus interfaces.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W entries.
- AF_THRESH, 6, almost_full asserted when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush, active-high.
- wr  input  1  write request.
- w_data  input  DATA_W  write data.
- rd  input  1  read request.
- r_data  output  DATA_W  read data, registered.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_empty  output  1  count <= AE_THRESH.
- almost_full  output  1  count >= AF_THRESH.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write rejected.
- underflow  output  1  sticky: read rejected.

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=rd_ptr=0, count=0, r_data=0, overflow=underflow=0. Hence empty=1, almost_empty=1, full=0, almost_full=0 (assuming AF_THRESH>=1). Memory contents are not reset.
- Storage: DEPTH x DATA_W register array. Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- Accept rules per cycle:
  - rd_ok = rd & ~empty.
  - wr_ok = wr & (~full | rd). A write into a full FIFO is accepted when a read occurs in the same cycle.
- On rising edge when rd_ok: r_data <= mem[rd_ptr]; rd_ptr++. Read latency is 1 cycle: data is valid after the edge that accepts rd. r_data holds its value when no read is accepted.
- On rising edge when wr_ok: mem[wr_ptr] <= w_data; wr_ptr++.
- count update:
  - +1 if wr_ok & ~rd_ok.
  - -1 if rd_ok & ~wr_ok.
  - Unchanged if both or neither are accepted.
- Empty and wr&rd together: write accepted, read rejected, underflow set, count becomes 1.
- Full and wr&rd together: both accepted, count stays DEPTH, no overflow.
- Error flags:
  - overflow <= 1 on any edge with wr & ~wr_ok.
  - underflow <= 1 on any edge with rd & empty.
  - Both are sticky until reset or clr.
- clr=1 (synchronous): pointers, count, overflow and underflow go to 0; r_data goes to 0. clr has priority over wr/rd in the same cycle, and those requests are discarded with no error flag set.
- Status flags are combinational decodes of the registered count only; there is no combinational path from wr/rd to the flags.
- Reset asserted mid-operation clears state immediately. The first operation after reset release behaves as on an empty FIFO.
- Data order is strict FIFO across pointer wrap-around.

Test Plan:
Configuration for all scenarios: DATA_W=8, ADDR_W=3, AF_THRESH=6, AE_THRESH=2.
1. Reset then idle -> empty=1, almost_empty=1, full=0, count=0, r_data=8'h00, overflow=underflow=0.
2. Write 8'h40,41,42,43,44,45,46,47 on 8 consecutive cycles -> count goes 1..8; almost_empty drops when count=3; almost_full rises when count=6; full=1 at count=8. A 9th write of 8'hFF -> overflow=1, count stays 8.
3. From full, read 8 cycles -> r_data is 40..47, one cycle after each accepted rd; empty=1 after the last read. One further rd -> underflow=1, r_data holds 8'h47.
4. Wrap-around: write 5 words, read 5, then write 6 (8'hA0..A5) and read 6 -> output is A0..A5 in order, count returns to 0.
5. Simultaneous: full with wr=rd=1 (w_data=8'hBB) -> count=8, no overflow, BB emerges last. Empty with wr=rd=1 -> count=1, underflow=1.
6. Flush and async reset: with count=4 and overflow=1, pulse clr together with wr=1 -> count=0, overflow=0, nothing written. Separately, assert reset mid-stream between clock edges -> count=0 immediately, not at the next edge.
